// File: rtl/trace_pkg.sv
// Shared types and helpers for the pipeline commit-trace monitor.
// Holds the event kind, the monitor FSM states, the default-configuration
// trace record layout and the saturating drop-counter helper.
package trace_pkg;

    // Default configuration of the monitor; the top-level parameters take
    // their defaults from here so the record below matches a default build.
    localparam int TRACE_DATA_W    = 32;
    localparam int TRACE_RF_AW     = 5;
    localparam int TRACE_DM_AW     = 7;
    localparam int TRACE_DEPTH     = 16;
    localparam int TRACE_MAX_COUNT = 203;
    localparam int TRACE_ADDR_W    = (TRACE_RF_AW > TRACE_DM_AW) ? TRACE_RF_AW : TRACE_DM_AW;
    localparam int TRACE_CYCLE_W   = $clog2(TRACE_MAX_COUNT + 1);

    // Source of a captured write: register file or data memory.
    typedef enum logic {
        KIND_RF = 1'b0,
        KIND_DM = 1'b1
    } trace_kind_e;

    // Monitor life cycle: wait for start, capture, empty the buffer, finished.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    // One trace record for the default configuration. The top level builds
    // the same field order with its own parameterised widths.
    typedef struct packed {
        trace_kind_e                kind;
        logic [TRACE_ADDR_W-1:0]    addr;
        logic [TRACE_DATA_W-1:0]    data;
        logic [TRACE_CYCLE_W-1:0]   cycle;
    } trace_entry_t;

    // Adds up to two dropped events to a 16-bit counter, sticking at all-ones.
    function automatic logic [15:0] satAdd16(input logic [15:0] base, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, base} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Dual-push, single-pop synchronous FIFO used to buffer trace records.
// The caller guarantees that it never pushes more entries than there is
// room for; a second push is only requested together with the first one.
// Pointers carry one extra bit so that full and empty can be told apart.
module trace_fifo
    import trace_pkg::*;
#(
    parameter  int DEPTH = TRACE_DEPTH,
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push0,
    input  logic [WIDTH-1:0] i_data0,
    input  logic             i_push1,
    input  logic [WIDTH-1:0] i_data1,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [PW:0]      o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wrPtr;
    logic [PW:0]      r_rdPtr;
    logic [PW:0]      w_wrPtrNext;
    logic [PW:0]      w_wrStep;
    logic             w_doPop;

    assign w_wrPtrNext = r_wrPtr + (PW+1)'(1);
    assign o_count     = r_wrPtr - r_rdPtr;
    assign o_empty     = (o_count == '0);
    assign o_head      = r_mem[r_rdPtr[PW-1:0]];
    assign w_doPop     = i_pop && !o_empty;

    // Number of slots the write pointer advances by this cycle.
    always_comb begin
        w_wrStep = '0;
        if (i_push0 && i_push1) begin
            w_wrStep = (PW+1)'(2);
        end else if (i_push0) begin
            w_wrStep = (PW+1)'(1);
        end
    end

    // Storage writes; the second record lands directly behind the first.
    always_ff @(posedge i_clk) begin
        if (i_push0) begin
            r_mem[r_wrPtr[PW-1:0]] <= i_data0;
        end
        if (i_push0 && i_push1) begin
            r_mem[w_wrPtrNext[PW-1:0]] <= i_data1;
        end
    end

    // Pointer maintenance; reset empties the buffer without touching storage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            r_wrPtr <= r_wrPtr + w_wrStep;
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_trace_monitor.sv
// Commit-trace monitor that snoops the register-file and data-memory write
// ports of the pipelined CPU, stamps every write with the run cycle count,
// buffers it and offers it on a valid/ready drain port. Capture stops after
// MAX_COUNT cycles and done_o rises once the buffer has been emptied.
// Build option: define TRACE_SKIP_R0_EN to ignore register writes to r0
// (they are then neither captured nor counted as drops).
module pipe_trace_monitor
    import trace_pkg::*;
#(
    parameter  int DATA_W    = TRACE_DATA_W,
    parameter  int RF_AW     = TRACE_RF_AW,
    parameter  int DM_AW     = TRACE_DM_AW,
    parameter  int DEPTH     = TRACE_DEPTH,
    parameter  int MAX_COUNT = TRACE_MAX_COUNT,
    localparam int CW        = $clog2(MAX_COUNT + 1),
    localparam int AW        = (RF_AW > DM_AW) ? RF_AW : DM_AW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              rf_we_i,
    input  logic [RF_AW-1:0]  rf_addr_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              dm_we_i,
    input  logic [DM_AW-1:0]  dm_addr_i,
    input  logic [DATA_W-1:0] dm_data_i,
    input  logic              rd_ready_i,
    output logic              rd_valid_o,
    output logic              rd_kind_o,
    output logic [AW-1:0]     rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CW-1:0]     rd_cycle_o,
    output logic [CW-1:0]     cycle_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       drop_cnt_o
);

    localparam int PW = $clog2(DEPTH);

    // Record layout held in the buffer, sized for this instance.
    typedef struct packed {
        trace_kind_e       kind;
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic [CW-1:0]     cycle;
    } entry_t;

    localparam int EW = $bits(entry_t);

    trace_state_e r_state;
    logic [CW-1:0] r_cycle;
    logic [15:0]   r_dropCnt;
    logic          r_busy;
    logic          r_done;

    logic          w_running;
    logic          w_rfReq;
    logic          w_dmReq;
    logic [1:0]    w_reqCnt;
    logic [1:0]    w_accCnt;
    logic [1:0]    w_dropCnt;
    logic [PW:0]   w_count;
    logic [PW:0]   w_free;
    logic          w_empty;
    logic          w_pop;
    logic          w_push0;
    logic          w_push1;
    entry_t        w_rfEntry;
    entry_t        w_dmEntry;
    entry_t        w_data0;
    entry_t        w_data1;
    logic [EW-1:0] w_headBits;
    entry_t        w_headRaw;
    entry_t        w_headShown;

    assign w_running = (r_state == ST_RUN);

`ifdef TRACE_SKIP_R0_EN
    assign w_rfReq = w_running && rf_we_i && (rf_addr_i != '0);
`else
    assign w_rfReq = w_running && rf_we_i;
`endif
    assign w_dmReq = w_running && dm_we_i;

    assign w_reqCnt = {1'b0, w_rfReq} + {1'b0, w_dmReq};
    assign w_free   = (PW+1)'(DEPTH) - w_count;
    assign w_pop    = rd_ready_i && !w_empty;

    // Assemble the candidate records from the snooped write ports.
    always_comb begin
        w_rfEntry       = '0;
        w_rfEntry.kind  = KIND_RF;
        w_rfEntry.addr  = AW'(rf_addr_i);
        w_rfEntry.data  = rf_data_i;
        w_rfEntry.cycle = r_cycle;
        w_dmEntry       = '0;
        w_dmEntry.kind  = KIND_DM;
        w_dmEntry.addr  = AW'(dm_addr_i);
        w_dmEntry.data  = dm_data_i;
        w_dmEntry.cycle = r_cycle;
    end

    // Decide how many requests fit, judged on occupancy at the start of the
    // cycle; a pop in the same cycle does not make room. The register write
    // always goes first, so with one free slot the memory write is the one lost.
    always_comb begin
        w_accCnt = w_reqCnt;
        if (w_free < (PW+1)'(w_reqCnt)) begin
            w_accCnt = w_free[1:0];
        end
        w_dropCnt = w_reqCnt - w_accCnt;
        w_push0   = (w_accCnt != 2'd0);
        w_push1   = (w_accCnt == 2'd2);
        w_data0   = w_rfReq ? w_rfEntry : w_dmEntry;
        w_data1   = w_dmEntry;
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push0 (w_push0),
        .i_data0 (w_data0),
        .i_push1 (w_push1),
        .i_data1 (w_data1),
        .i_pop   (w_pop),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_headBits)
    );

    // Present the head record, forced to zero whenever the buffer is empty so
    // stale storage never shows on the drain port.
    always_comb begin
        w_headRaw   = w_headBits;
        w_headShown = w_empty ? '0 : w_headRaw;
    end

    assign rd_valid_o = !w_empty;
    assign rd_kind_o  = w_headShown.kind;
    assign rd_addr_o  = w_headShown.addr;
    assign rd_data_o  = w_headShown.data;
    assign rd_cycle_o = w_headShown.cycle;

    // Run-control FSM with the cycle counter and registered status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cycle <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en_i) begin
                        r_state <= ST_RUN;
                        r_cycle <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_cycle == CW'(MAX_COUNT - 1)) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_cycle <= r_cycle + CW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_empty && !w_pop) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Count events that found no room in the buffer, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dropCnt <= '0;
        end else begin
            r_dropCnt <= satAdd16(r_dropCnt, w_dropCnt);
        end
    end

    assign cycle_o    = r_cycle;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign drop_cnt_o = r_dropCnt;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Directed bench for pipe_trace_monitor with a short run (8 cycles) and a
// 4-entry buffer. Each step drives one cycle of inputs and checks every
// output after the rising edge against hand-computed values.
module tb_pipe_trace_monitor;

    localparam int DATA_W    = 32;
    localparam int RF_AW     = 5;
    localparam int DM_AW     = 7;
    localparam int DEPTH     = 4;
    localparam int MAX_COUNT = 8;
    localparam int CW        = 4;
    localparam int AW        = 7;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              en_i = 1'b0;
    logic              rf_we_i = 1'b0;
    logic [RF_AW-1:0]  rf_addr_i = '0;
    logic [DATA_W-1:0] rf_data_i = '0;
    logic              dm_we_i = 1'b0;
    logic [DM_AW-1:0]  dm_addr_i = '0;
    logic [DATA_W-1:0] dm_data_i = '0;
    logic              rd_ready_i = 1'b0;
    logic              rd_valid_o;
    logic              rd_kind_o;
    logic [AW-1:0]     rd_addr_o;
    logic [DATA_W-1:0] rd_data_o;
    logic [CW-1:0]     rd_cycle_o;
    logic [CW-1:0]     cycle_o;
    logic              busy_o;
    logic              done_o;
    logic [15:0]       drop_cnt_o;

    int testsRun  = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    pipe_trace_monitor #(
        .DATA_W    (DATA_W),
        .RF_AW     (RF_AW),
        .DM_AW     (DM_AW),
        .DEPTH     (DEPTH),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .rf_we_i    (rf_we_i),
        .rf_addr_i  (rf_addr_i),
        .rf_data_i  (rf_data_i),
        .dm_we_i    (dm_we_i),
        .dm_addr_i  (dm_addr_i),
        .dm_data_i  (dm_data_i),
        .rd_ready_i (rd_ready_i),
        .rd_valid_o (rd_valid_o),
        .rd_kind_o  (rd_kind_o),
        .rd_addr_o  (rd_addr_o),
        .rd_data_o  (rd_data_o),
        .rd_cycle_o (rd_cycle_o),
        .cycle_o    (cycle_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .drop_cnt_o (drop_cnt_o)
    );

    typedef struct packed {
        logic              rst;
        logic              en;
        logic              rfWe;
        logic [RF_AW-1:0]  rfAddr;
        logic [DATA_W-1:0] rfData;
        logic              dmWe;
        logic [DM_AW-1:0]  dmAddr;
        logic [DATA_W-1:0] dmData;
        logic              rdReady;
    } stim_t;

    typedef struct packed {
        logic              valid;
        logic              kind;
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic [CW-1:0]     rcyc;
        logic [CW-1:0]     cyc;
        logic              busy;
        logic              done;
        logic [15:0]       drop;
    } expect_t;

    typedef struct {
        string   name;
        stim_t   stim;
        expect_t exp;
    } vector_t;

    function automatic stim_t st(input logic rst, input logic en,
                                 input logic rfWe, input logic [RF_AW-1:0] rfAddr, input logic [DATA_W-1:0] rfData,
                                 input logic dmWe, input logic [DM_AW-1:0] dmAddr, input logic [DATA_W-1:0] dmData,
                                 input logic rdReady);
        stim_t s;
        s.rst = rst; s.en = en;
        s.rfWe = rfWe; s.rfAddr = rfAddr; s.rfData = rfData;
        s.dmWe = dmWe; s.dmAddr = dmAddr; s.dmData = dmData;
        s.rdReady = rdReady;
        return s;
    endfunction

    function automatic expect_t ex(input logic valid, input logic kind, input logic [AW-1:0] addr,
                                   input logic [DATA_W-1:0] data, input logic [CW-1:0] rcyc,
                                   input logic [CW-1:0] cyc, input logic busy, input logic done,
                                   input logic [15:0] drop);
        expect_t e;
        e.valid = valid; e.kind = kind; e.addr = addr; e.data = data; e.rcyc = rcyc;
        e.cyc = cyc; e.busy = busy; e.done = done; e.drop = drop;
        return e;
    endfunction

    // Drive one cycle of inputs away from the active edge and wait past it.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        rst_i      = s.rst;
        en_i       = s.en;
        rf_we_i    = s.rfWe;
        rf_addr_i  = s.rfAddr;
        rf_data_i  = s.rfData;
        dm_we_i    = s.dmWe;
        dm_addr_i  = s.dmAddr;
        dm_data_i  = s.dmData;
        rd_ready_i = s.rdReady;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input expect_t e);
        expect_t act;
        act.valid = rd_valid_o; act.kind = rd_kind_o; act.addr = rd_addr_o;
        act.data = rd_data_o; act.rcyc = rd_cycle_o; act.cyc = cycle_o;
        act.busy = busy_o; act.done = done_o; act.drop = drop_cnt_o;
        testsRun++;
        if (act !== e) begin
            failCount++;
            $display("[TB] FAIL %s: got v=%b k=%b a=%h d=%h rc=%0d c=%0d busy=%b done=%b drop=%0d, expected v=%b k=%b a=%h d=%h rc=%0d c=%0d busy=%b done=%b drop=%0d",
                     name, act.valid, act.kind, act.addr, act.data, act.rcyc, act.cyc, act.busy, act.done, act.drop,
                     e.valid, e.kind, e.addr, e.data, e.rcyc, e.cyc, e.busy, e.done, e.drop);
        end
    endtask

    task automatic step(input string name, input stim_t s, input expect_t e);
        applyStimulus(s);
        checkOutput(name, e);
    endtask

    // Watchdog so the bench always ends even if the flow stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    vector_t vecs[21];
    stim_t   idle;
    stim_t   rstS;
    expect_t zero;

    initial begin
        idle = st(0, 0, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 0);
        rstS = st(1, 0, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 0);
        zero = ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd0, 0, 0, 16'd0);

        // Single register write, drained after the run ends, then DONE.
        vecs[0]  = '{"reset",        rstS, zero};
        vecs[1]  = '{"idle hold",    idle, zero};
        vecs[2]  = '{"start",        st(0, 1, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 0), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd0, 1, 0, 16'd0)};
        vecs[3]  = '{"run c1",       idle, ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd1, 1, 0, 16'd0)};
        vecs[4]  = '{"run c2",       idle, ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd2, 1, 0, 16'd0)};
        vecs[5]  = '{"rf r3 at c2",  st(0, 0, 1, 5'd3, 32'h55, 0, 7'd0, 32'h0, 0), ex(1, 0, 7'h3, 32'h55, 4'd2, 4'd3, 1, 0, 16'd0)};
        vecs[6]  = '{"stall c4",     idle, ex(1, 0, 7'h3, 32'h55, 4'd2, 4'd4, 1, 0, 16'd0)};
        vecs[7]  = '{"stall c5",     idle, ex(1, 0, 7'h3, 32'h55, 4'd2, 4'd5, 1, 0, 16'd0)};
        vecs[8]  = '{"stall c6",     idle, ex(1, 0, 7'h3, 32'h55, 4'd2, 4'd6, 1, 0, 16'd0)};
        vecs[9]  = '{"stall c7",     idle, ex(1, 0, 7'h3, 32'h55, 4'd2, 4'd7, 1, 0, 16'd0)};
        vecs[10] = '{"enter drain",  idle, ex(1, 0, 7'h3, 32'h55, 4'd2, 4'd7, 1, 0, 16'd0)};
        vecs[11] = '{"pop in drain", st(0, 0, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 1), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd7, 1, 0, 16'd0)};
        vecs[12] = '{"done",         idle, ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd7, 0, 1, 16'd0)};
        vecs[13] = '{"done ignores", st(0, 1, 1, 5'd3, 32'h1, 1, 7'd1, 32'h2, 1), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd7, 0, 1, 16'd0)};
        // Strobes in IDLE, en in RUN, and a same-cycle register+memory pair.
        vecs[14] = '{"reset2",       rstS, zero};
        vecs[15] = '{"idle strobes", st(0, 0, 1, 5'd4, 32'h7, 1, 7'd8, 32'h9, 1), zero};
        vecs[16] = '{"start2",       st(0, 1, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 0), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd0, 1, 0, 16'd0)};
        vecs[17] = '{"en in run",    st(0, 1, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 0), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd1, 1, 0, 16'd0)};
        vecs[18] = '{"dual at c1",   st(0, 0, 1, 5'd4, 32'h7, 1, 7'd8, 32'h9, 0), ex(1, 0, 7'h4, 32'h7, 4'd1, 4'd2, 1, 0, 16'd0)};
        vecs[19] = '{"pop rf",       st(0, 0, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 1), ex(1, 1, 7'h8, 32'h9, 4'd1, 4'd3, 1, 0, 16'd0)};
        vecs[20] = '{"pop dm",       st(0, 0, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 1), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd4, 1, 0, 16'd0)};

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].name, vecs[i].stim, vecs[i].exp);
        end

        // Overflow: one free slot keeps the register write, a full buffer
        // drops everything even while a pop is happening.
        step("ovf reset",      rstS, zero);
        step("ovf start",      st(0, 1, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 0), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd0, 1, 0, 16'd0));
        step("ovf c0 both",    st(0, 0, 1, 5'd1, 32'h11, 1, 7'd2, 32'h22, 0), ex(1, 0, 7'h1, 32'h11, 4'd0, 4'd1, 1, 0, 16'd0));
        step("ovf c1 rf",      st(0, 0, 1, 5'd3, 32'h33, 0, 7'd0, 32'h0, 0), ex(1, 0, 7'h1, 32'h11, 4'd0, 4'd2, 1, 0, 16'd0));
        step("ovf c2 one free", st(0, 0, 1, 5'd5, 32'h55, 1, 7'd6, 32'h66, 0), ex(1, 0, 7'h1, 32'h11, 4'd0, 4'd3, 1, 0, 16'd1));
        step("ovf c3 full pop", st(0, 0, 1, 5'd7, 32'h77, 0, 7'd0, 32'h0, 1), ex(1, 1, 7'h2, 32'h22, 4'd0, 4'd4, 1, 0, 16'd2));
        step("ovf drain2",     st(0, 0, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 1), ex(1, 0, 7'h3, 32'h33, 4'd1, 4'd5, 1, 0, 16'd2));
        step("ovf drain3",     st(0, 0, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 1), ex(1, 0, 7'h5, 32'h55, 4'd2, 4'd6, 1, 0, 16'd2));
        step("ovf drain4",     st(0, 0, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 1), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd7, 1, 0, 16'd2));

        // Reset in the middle of a run with three entries queued.
        step("mid reset",      rstS, zero);
        step("mid start",      st(0, 1, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 0), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd0, 1, 0, 16'd0));
        step("mid push0",      st(0, 0, 1, 5'd1, 32'hA, 0, 7'd0, 32'h0, 0), ex(1, 0, 7'h1, 32'hA, 4'd0, 4'd1, 1, 0, 16'd0));
        step("mid push1",      st(0, 0, 1, 5'd2, 32'hB, 0, 7'd0, 32'h0, 0), ex(1, 0, 7'h1, 32'hA, 4'd0, 4'd2, 1, 0, 16'd0));
        step("mid push2",      st(0, 0, 1, 5'd3, 32'hC, 0, 7'd0, 32'h0, 0), ex(1, 0, 7'h1, 32'hA, 4'd0, 4'd3, 1, 0, 16'd0));
        step("mid c3",         idle, ex(1, 0, 7'h1, 32'hA, 4'd0, 4'd4, 1, 0, 16'd0));
        step("mid c4",         idle, ex(1, 0, 7'h1, 32'hA, 4'd0, 4'd5, 1, 0, 16'd0));
        step("mid rst at c5",  rstS, zero);
        step("mid restart",    st(0, 1, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 0), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd0, 1, 0, 16'd0));
        step("mid new push",   st(0, 0, 1, 5'd9, 32'h99, 0, 7'd0, 32'h0, 0), ex(1, 0, 7'h9, 32'h99, 4'd0, 4'd1, 1, 0, 16'd0));
        step("mid new pop",    st(0, 0, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 1), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd2, 1, 0, 16'd0));

        // Write to r0: skipped only when the build option is enabled.
        step("r0 reset",       rstS, zero);
        step("r0 start",       st(0, 1, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 0), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd0, 1, 0, 16'd0));
`ifdef TRACE_SKIP_R0_EN
        step("r0 write",       st(0, 0, 1, 5'd0, 32'h1, 0, 7'd0, 32'h0, 0), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd1, 1, 0, 16'd0));
`else
        step("r0 write",       st(0, 0, 1, 5'd0, 32'h1, 0, 7'd0, 32'h0, 0), ex(1, 0, 7'h0, 32'h1, 4'd0, 4'd1, 1, 0, 16'd0));
`endif
        step("r0 after",       st(0, 0, 0, 5'd0, 32'h0, 0, 7'd0, 32'h0, 1), ex(0, 0, 7'h0, 32'h0, 4'd0, 4'd2, 1, 0, 16'd0));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
